controller_hub: RTL and testbench
=================================

Name: controller_hub

Overview:
- Parametrised successor to the fixed two-port controller interface: one engine serves NUM_CONTROLLERS NES-style serial pads on a shared latch/clock pair.
- Triggered once per frame by the GPU vblank fetch strobe.
- Holds a committed, atomically updated button snapshot per pad.
- The CPU reads it through an indexed read port driven by the address decoder.

Parameters:
- NUM_CONTROLLERS, 2, number of serial pads (1..8).
- BITS_PER_CONTROLLER, 8, bits shifted per pad per fetch.
- CLK_DIV, 4, cpu_clk cycles per half-period of controller_clk (>=1).

Ports:
- cpu_clk  in  1  sole clock.
- rst_B  in  1  asynchronous reset, active-low.
- start_fetch  in  1  request to fetch; sampled high for one cycle.
- controller_clk  out  1  shared shift clock to all pads.
- controller_latch  out  1  shared parallel-load strobe to all pads.
- controller_data_in_B  in  NUM_CONTROLLERS  serial data per pad, active-low (0 = pressed).
- read_index  in  $clog2(NUM_CONTROLLERS) (min 1)  pad selected for CPU read.
- data_out  out  BITS_PER_CONTROLLER  committed buttons of the selected pad, 1 = pressed.
- pressed_edge_out  out  BITS_PER_CONTROLLER  newly pressed buttons of the selected pad (see Optional Feature).
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle pulse when the snapshot commits.
- missed_fetch  out  1  sticky flag: a start_fetch arrived while busy.

Behaviour:
- Reset (rst_B low, asynchronous) forces the following immediately, including mid-fetch:
  - state IDLE; controller_clk=0, controller_latch=0.
  - busy=0, done=0, missed_fetch=0.
  - all shift and snapshot registers cleared to 0.
- After reset release, no fetch starts until a new start_fetch is sampled.
- FSM states: IDLE, LATCH, PRE_LOW, HIGH, LOW, COMMIT.
  - IDLE: start_fetch=1 at an edge goes to LATCH; missed_fetch clears on that same edge.
  - LATCH: controller_latch=1 for 2*CLK_DIV cycles, then PRE_LOW.
  - PRE_LOW: both outputs 0 for CLK_DIV cycles. On the last cycle, sample bit 0 of every pad, then go to HIGH (or COMMIT if BITS_PER_CONTROLLER=1).
  - HIGH: controller_clk=1 for CLK_DIV cycles, then LOW.
  - LOW: controller_clk=0 for CLK_DIV cycles. On the last cycle, sample the next bit. If it was bit BITS_PER_CONTROLLER-1, go to COMMIT, else go to HIGH.
  - COMMIT: one cycle. At its closing edge, all pad snapshots update simultaneously and done=1 for the following cycle. Then IDLE.
- Sampling:
  - Stored bit = ~controller_data_in_B[i].
  - Shift left: the first received bit ends in the MSB (bit BITS_PER_CONTROLLER-1), the last in bit 0.
- Exactly BITS_PER_CONTROLLER-1 controller_clk pulses per fetch; no trailing pulse.
- Latency: start_fetch sampled at edge E0 gives the snapshot update plus done at edge E0 + 2D + D + 2D*(BITS_PER_CONTROLLER-1) + 1, where D=CLK_DIV. Defaults: E0+69.
- busy=1 from the edge after E0 through the COMMIT cycle.
- start_fetch while busy is ignored and sets missed_fetch=1, which holds until the next accepted start_fetch.
- start_fetch high during COMMIT is also ignored (busy).
- data_out is combinational from committed snapshots only. It never shows partial shift data and is stable for the whole fetch.
- read_index >= NUM_CONTROLLERS gives data_out=0 and pressed_edge_out=0.
- All pads share timing; per-pad shift registers are independent.

Optional Feature:
- Macro: CONTROLLER_HUB_PRESS_EDGE_EN.
- Defined: a per-pad edge register updates at COMMIT to new_snapshot & ~old_snapshot. pressed_edge_out shows it for read_index and clears on reset.
- Undefined: no edge registers are built and pressed_edge_out is tied to 0.

Test Plan:
- Defaults, pad0 model returns A..Right = pressed,released,pressed,released,released,released,released,pressed (pad0 data_in_B sequence 0,1,0,1,1,1,1,0), pad1 all released; pulse start_fetch -> latch high 8 cycles, 7 controller_clk pulses, done at E0+69; read_index=0 gives data_out=8'hA1, read_index=1 gives 8'h00.
- Pulse start_fetch again 20 cycles after E0 -> ignored, missed_fetch=1 and holds; next start_fetch after done clears it and runs a normal 69-cycle fetch.
- Assert rst_B low during the 4th HIGH phase -> controller_clk, controller_latch, busy and data_out are 0 immediately; no done; fetch restarts only on a new start_fetch.
- NUM_CONTROLLERS=4, BITS_PER_CONTROLLER=12, CLK_DIV=2; pads driven with distinct patterns -> all four snapshots correct, done at E0+51, read_index=3 returns pad3.
- NUM_CONTROLLERS=3, read_index=3 -> data_out=0.
- With CONTROLLER_HUB_PRESS_EDGE_EN: fetch pad0 = 8'h81, then 8'hC0 -> pressed_edge_out=8'h40 after the second done. Without the macro, pressed_edge_out=0 throughout.

Source files
------------

// File: rtl/controller_hub.sv
// controller_hub: one serial engine serving NUM_CONTROLLERS NES-style pads on a
// shared latch/clock pair. A fetch latches every pad, shifts BITS_PER_CONTROLLER
// bits out of each, then commits all pad snapshots in one cycle so the CPU read
// port never sees partial data.
// Optional build macro: CONTROLLER_HUB_PRESS_EDGE_EN adds per-pad newly-pressed
// registers behind pressed_edge_out; without it that port is tied to zero.
`timescale 1ns/1ps
module controller_hub #(
  parameter int NUM_CONTROLLERS     = 2,
  parameter int BITS_PER_CONTROLLER = 8,
  parameter int CLK_DIV             = 4,
  localparam int IDX_W = (NUM_CONTROLLERS > 1) ? $clog2(NUM_CONTROLLERS) : 1
) (
  input  logic                           cpu_clk,
  input  logic                           rst_B,
  input  logic                           start_fetch,
  output logic                           controller_clk,
  output logic                           controller_latch,
  input  logic [NUM_CONTROLLERS-1:0]     controller_data_in_B,
  input  logic [IDX_W-1:0]               read_index,
  output logic [BITS_PER_CONTROLLER-1:0] data_out,
  output logic [BITS_PER_CONTROLLER-1:0] pressed_edge_out,
  output logic                           busy,
  output logic                           done,
  output logic                           missed_fetch
);

  localparam int CNT_W = $clog2(2 * CLK_DIV + 1);
  localparam int BIT_W = $clog2(BITS_PER_CONTROLLER + 1);

  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(BITS_PER_CONTROLLER - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LATCH   = 3'd1;
  localparam logic [2:0] PRE_LOW = 3'd2;
  localparam logic [2:0] HIGH    = 3'd3;
  localparam logic [2:0] LOW     = 3'd4;
  localparam logic [2:0] COMMIT  = 3'd5;

  logic [2:0]                     state_r;
  logic [2:0]                     state_s;
  logic [CNT_W-1:0]               cnt_r;
  logic [BIT_W-1:0]               bit_idx_r;
  logic                           sample_s;
  logic [BITS_PER_CONTROLLER-1:0] shift_r [NUM_CONTROLLERS];
  logic [BITS_PER_CONTROLLER-1:0] snap_r  [NUM_CONTROLLERS];

  // Shift one received bit in at the LSB; the first bit migrates to the MSB.
  function automatic logic [BITS_PER_CONTROLLER-1:0] shift_in(
    input logic [BITS_PER_CONTROLLER-1:0] cur,
    input logic                           bit_in
  );
    logic [BITS_PER_CONTROLLER-1:0] res;
    res    = cur << 1'b1;
    res[0] = bit_in;
    return res;
  endfunction

  // Next-state decode; sample_s marks the closing cycle of PRE_LOW/LOW.
  always_comb begin
    state_s  = state_r;
    sample_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_fetch) state_s = LATCH;
        else             state_s = IDLE;
      end
      LATCH: begin
        if (cnt_r == LATCH_LAST) state_s = PRE_LOW;
        else                     state_s = LATCH;
      end
      PRE_LOW: begin
        if (cnt_r == HALF_LAST) begin
          sample_s = 1'b1;
          state_s  = (BITS_PER_CONTROLLER == 1) ? COMMIT : HIGH;
        end else begin
          state_s = PRE_LOW;
        end
      end
      HIGH: begin
        if (cnt_r == HALF_LAST) state_s = LOW;
        else                    state_s = HIGH;
      end
      LOW: begin
        if (cnt_r == HALF_LAST) begin
          sample_s = 1'b1;
          if (bit_idx_r == BIT_LAST) state_s = COMMIT;
          else                       state_s = HIGH;
        end else begin
          state_s = LOW;
        end
      end
      COMMIT:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Sequencer state, phase counters and registered pad/status outputs.
  always_ff @(posedge cpu_clk or negedge rst_B) begin
    if (!rst_B) begin
      state_r          <= IDLE;
      cnt_r            <= {CNT_W{1'b0}};
      bit_idx_r        <= {BIT_W{1'b0}};
      controller_clk   <= 1'b0;
      controller_latch <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      missed_fetch     <= 1'b0;
    end else begin
      state_r <= state_s;
      if (state_s != state_r || state_r == IDLE) cnt_r <= {CNT_W{1'b0}};
      else                                       cnt_r <= cnt_r + CNT_W'(1);
      if (sample_s)             bit_idx_r <= bit_idx_r + BIT_W'(1);
      else if (state_r == IDLE) bit_idx_r <= {BIT_W{1'b0}};
      controller_clk   <= (state_s == HIGH);
      controller_latch <= (state_s == LATCH);
      busy             <= (state_s != IDLE);
      done             <= (state_r == COMMIT);
      // An accepted request clears the flag; any request while busy sets it.
      if (state_r == IDLE) begin
        if (start_fetch) missed_fetch <= 1'b0;
      end else if (start_fetch) begin
        missed_fetch <= 1'b1;
      end
    end
  end

  // Per-pad shift registers and the atomically committed snapshots.
  always_ff @(posedge cpu_clk or negedge rst_B) begin
    if (!rst_B) begin
      for (int i = 0; i < NUM_CONTROLLERS; i++) begin
        shift_r[i] <= {BITS_PER_CONTROLLER{1'b0}};
        snap_r[i]  <= {BITS_PER_CONTROLLER{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_CONTROLLERS; i++) begin
        if (sample_s) shift_r[i] <= shift_in(shift_r[i], ~controller_data_in_B[i]);
        if (state_r == COMMIT) snap_r[i] <= shift_r[i];
      end
    end
  end

`ifdef CONTROLLER_HUB_PRESS_EDGE_EN
  logic [BITS_PER_CONTROLLER-1:0] edge_r [NUM_CONTROLLERS];

  // Buttons that went from released to pressed across the latest commit.
  always_ff @(posedge cpu_clk or negedge rst_B) begin
    if (!rst_B) begin
      for (int i = 0; i < NUM_CONTROLLERS; i++) edge_r[i] <= {BITS_PER_CONTROLLER{1'b0}};
    end else begin
      for (int i = 0; i < NUM_CONTROLLERS; i++) begin
        if (state_r == COMMIT) edge_r[i] <= shift_r[i] & ~snap_r[i];
      end
    end
  end
`endif

  // CPU read mux over committed state only; out-of-range pads read as zero.
  always_comb begin
    data_out         = {BITS_PER_CONTROLLER{1'b0}};
    pressed_edge_out = {BITS_PER_CONTROLLER{1'b0}};
    if (int'(read_index) < NUM_CONTROLLERS) begin
      data_out = snap_r[read_index];
`ifdef CONTROLLER_HUB_PRESS_EDGE_EN
      pressed_edge_out = edge_r[read_index];
`else
      pressed_edge_out = {BITS_PER_CONTROLLER{1'b0}};
`endif
    end else begin
      data_out         = {BITS_PER_CONTROLLER{1'b0}};
      pressed_edge_out = {BITS_PER_CONTROLLER{1'b0}};
    end
  end

endmodule

// File: tb/tb_controller_hub.sv
// Directed bench for controller_hub: three instances (default, 4x12 bits at
// CLK_DIV=2, and 3 pads at CLK_DIV=1) each fed by a small NES pad model.
`timescale 1ns/1ps
module tb_controller_hub;

  logic clk = 1'b0;
  logic rst_B = 1'b1;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- instance 1: defaults ----------------
  logic       start1 = 1'b0, cclk1, lat1, busy1, done1, missed1;
  logic [1:0] din1;
  logic       ridx1 = 1'b0;
  logic [7:0] dout1, edge1;
  logic [7:0] seq1 [2];
  logic [2:0] idx1;
  logic       cclk1_d;
  logic       mon_clr = 1'b0;
  int         lat_cnt1, pulse_cnt1;

  controller_hub u1 (
    .cpu_clk(clk), .rst_B(rst_B), .start_fetch(start1),
    .controller_clk(cclk1), .controller_latch(lat1),
    .controller_data_in_B(din1), .read_index(ridx1),
    .data_out(dout1), .pressed_edge_out(edge1),
    .busy(busy1), .done(done1), .missed_fetch(missed1)
  );

  // ---------------- instance 2: 4 pads, 12 bits, CLK_DIV 2 ----------------
  logic        start2 = 1'b0, cclk2, lat2, busy2, done2, missed2;
  logic [3:0]  din2;
  logic [1:0]  ridx2 = 2'd0;
  logic [11:0] dout2, edge2;
  logic [11:0] seq2 [4];
  logic [3:0]  idx2;
  logic        cclk2_d;

  controller_hub #(.NUM_CONTROLLERS(4), .BITS_PER_CONTROLLER(12), .CLK_DIV(2)) u2 (
    .cpu_clk(clk), .rst_B(rst_B), .start_fetch(start2),
    .controller_clk(cclk2), .controller_latch(lat2),
    .controller_data_in_B(din2), .read_index(ridx2),
    .data_out(dout2), .pressed_edge_out(edge2),
    .busy(busy2), .done(done2), .missed_fetch(missed2)
  );

  // ---------------- instance 3: 3 pads, 8 bits, CLK_DIV 1 ----------------
  logic       start3 = 1'b0, cclk3, lat3, busy3, done3, missed3;
  logic [2:0] din3;
  logic [1:0] ridx3 = 2'd0;
  logic [7:0] dout3, edge3;
  logic [7:0] seq3 [3];
  logic [2:0] idx3;
  logic       cclk3_d;

  controller_hub #(.NUM_CONTROLLERS(3), .BITS_PER_CONTROLLER(8), .CLK_DIV(1)) u3 (
    .cpu_clk(clk), .rst_B(rst_B), .start_fetch(start3),
    .controller_clk(cclk3), .controller_latch(lat3),
    .controller_data_in_B(din3), .read_index(ridx3),
    .data_out(dout3), .pressed_edge_out(edge3),
    .busy(busy3), .done(done3), .missed_fetch(missed3)
  );

  // Pad models: latch reloads bit 0, each controller_clk rise advances a bit.
  always @(posedge clk) begin
    cclk1_d <= cclk1;
    cclk2_d <= cclk2;
    cclk3_d <= cclk3;
    if (!rst_B || lat1) idx1 <= 3'd0;
    else if (cclk1 && !cclk1_d) idx1 <= idx1 + 3'd1;
    if (!rst_B || lat2) idx2 <= 4'd0;
    else if (cclk2 && !cclk2_d) idx2 <= idx2 + 4'd1;
    if (!rst_B || lat3) idx3 <= 3'd0;
    else if (cclk3 && !cclk3_d) idx3 <= idx3 + 3'd1;
  end

  assign din1 = {seq1[1][idx1], seq1[0][idx1]};
  assign din2 = {seq2[3][idx2], seq2[2][idx2], seq2[1][idx2], seq2[0][idx2]};
  assign din3 = {seq3[2][idx3], seq3[1][idx3], seq3[0][idx3]};

  // Counts latch-high cycles and controller_clk rising edges of instance 1.
  always @(posedge clk) begin
    if (mon_clr) begin
      lat_cnt1   <= 0;
      pulse_cnt1 <= 0;
    end else begin
      if (lat1) lat_cnt1 <= lat_cnt1 + 1;
      if (cclk1 && !cclk1_d) pulse_cnt1 <= pulse_cnt1 + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sel_done(input int which);
    case (which)
      1:       return done1;
      2:       return done2;
      3:       return done3;
      default: return 1'b0;
    endcase
  endfunction

  // Start is sampled at edge E0; returns #1 after E0.
  task automatic pulse_start(input int which);
    @(negedge clk);
    case (which)
      1:       start1 = 1'b1;
      2:       start2 = 1'b1;
      3:       start3 = 1'b1;
      default: start1 = 1'b0;
    endcase
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start2 = 1'b0;
    start3 = 1'b0;
  endtask

  // Counts edges until done is seen; -1 if the budget expires.
  task automatic wait_done(input int which, input int budget, output int n);
    n = -1;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk);
      #1;
      if (sel_done(which)) begin
        n = k;
        break;
      end
    end
  endtask

  logic [11:0] exp2 [4];
  logic [7:0]  exp_edge;
  int          n;
  logic        done_seen, busy_seen;

  initial begin
    seq1[0] = 8'hFF; seq1[1] = 8'hFF;
    for (int p = 0; p < 4; p++) seq2[p] = 12'hFFF;
    for (int p = 0; p < 3; p++) seq3[p] = 8'hFF;

    // Reset state, asserted before any clock edge.
    #2 rst_B = 1'b0;
    #1;
    check("rst cclk", cclk1, 1'b0);
    check("rst latch", lat1, 1'b0);
    check("rst busy", busy1, 1'b0);
    check("rst done", done1, 1'b0);
    check("rst missed", missed1, 1'b0);
    check("rst data", dout1, 8'h00);
    @(negedge clk) rst_B = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("no self start", busy1, 1'b0);

    // Basic fetch: pad0 line sequence 0,1,0,1,1,1,1,0 -> A1; pad1 released.
    seq1[0] = 8'h7A;
    mon_clr = 1'b1;
    @(posedge clk);
    #1 mon_clr = 1'b0;
    pulse_start(1);
    check("busy after E0", busy1, 1'b1);
    wait_done(1, 100, n);
    check("latency 69", n, 69);
    check("latch cycles", lat_cnt1, 8);
    check("clk pulses", pulse_cnt1, 7);
    ridx1 = 1'b0; #1;
    check("pad0 data", dout1, 8'hA1);
`ifdef CONTROLLER_HUB_PRESS_EDGE_EN
    exp_edge = 8'hA1;
`else
    exp_edge = 8'h00;
`endif
    check("pad0 edge first", edge1, exp_edge);
    ridx1 = 1'b1; #1;
    check("pad1 data", dout1, 8'h00);
    ridx1 = 1'b0;
    @(posedge clk); #1;
    check("done one cycle", done1, 1'b0);
    check("idle after commit", busy1, 1'b0);

    // Request while busy is dropped and flagged until the next accepted one.
    pulse_start(1);
    repeat (19) @(posedge clk);
    #1;
    pulse_start(1);
    check("missed set", missed1, 1'b1);
    wait_done(1, 100, n);
    check("missed latency", n, 49);
    check("missed held at done", missed1, 1'b1);
    check("data after missed", dout1, 8'hA1);
    @(posedge clk); #1;
    check("missed held idle", missed1, 1'b1);
    check("no extra fetch", busy1, 1'b0);
    pulse_start(1);
    check("missed cleared", missed1, 1'b0);
    wait_done(1, 100, n);
    check("relaunch latency", n, 69);

    // Edge feature: 81 then C0 -> newly pressed 40.
    seq1[0] = 8'h7E;
    pulse_start(1);
    wait_done(1, 100, n);
    check("fetch 81 latency", n, 69);
    check("pad0 81", dout1, 8'h81);
    seq1[0] = 8'hFC;
    pulse_start(1);
    repeat (39) @(posedge clk);
    #1;
    check("stable mid fetch", dout1, 8'h81);
    wait_done(1, 100, n);
    check("fetch C0 latency", n, 30);
    check("pad0 C0", dout1, 8'hC0);
`ifdef CONTROLLER_HUB_PRESS_EDGE_EN
    exp_edge = 8'h40;
`else
    exp_edge = 8'h00;
`endif
    check("pad0 edge 40", edge1, exp_edge);

    // Four pads, 12 bits, CLK_DIV 2.
    seq2[0] = 12'hFFE; exp2[0] = 12'h800;
    seq2[1] = 12'h7FF; exp2[1] = 12'h001;
    seq2[2] = 12'hAAA; exp2[2] = 12'hAAA;
    seq2[3] = 12'hFF0; exp2[3] = 12'hF00;
    pulse_start(2);
    wait_done(2, 200, n);
    check("u2 latency 51", n, 51);
    for (int p = 0; p < 4; p++) begin
      ridx2 = 2'(p);
      #1;
      check($sformatf("u2 pad%0d", p), dout2, exp2[p]);
    end
`ifdef CONTROLLER_HUB_PRESS_EDGE_EN
    check("u2 pad3 edge", edge2, 12'hF00);
`else
    check("u2 pad3 edge", edge2, 12'h000);
`endif

    // Three pads: index 3 is out of range.
    for (int p = 0; p < 3; p++) seq3[p] = 8'h00;
    pulse_start(3);
    wait_done(3, 100, n);
    check("u3 latency 18", n, 18);
    ridx3 = 2'd2; #1;
    check("u3 pad2", dout3, 8'hFF);
    ridx3 = 2'd3; #1;
    check("u3 idx3 data", dout3, 8'h00);
    check("u3 idx3 edge", edge3, 8'h00);

    // Reset during the 4th HIGH phase of instance 1.
    pulse_start(1);
    repeat (37) @(posedge clk);
    #1;
    check("in HIGH4", cclk1, 1'b1);
    #1 rst_B = 1'b0;
    #1;
    check("mid rst cclk", cclk1, 1'b0);
    check("mid rst latch", lat1, 1'b0);
    check("mid rst busy", busy1, 1'b0);
    check("mid rst data", dout1, 8'h00);
    @(negedge clk) rst_B = 1'b1;
    done_seen = 1'b0;
    busy_seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      done_seen = done_seen | done1;
      busy_seen = busy_seen | busy1;
    end
    check("no done after rst", done_seen, 1'b0);
    check("no restart after rst", busy_seen, 1'b0);
    seq1[0] = 8'h7A;
    pulse_start(1);
    wait_done(1, 100, n);
    check("post rst latency", n, 69);
    check("post rst data", dout1, 8'hA1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
